// File: rtl/com_divide_sequencer.sv
// Centroid divider: one serial restoring divider computes floor(xTop/total) then
// floor(yTop/total), saturates each to QMAX and publishes them with a valid pulse.
module com_divide_sequencer #(
    parameter logic [19:0] MIN_TOTAL = 20'd1,
    parameter logic [9:0]  QMAX      = 10'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [28:0] xTop,
    input  logic [28:0] yTop,
    input  logic [19:0] total,
    output logic [9:0]  xCenter,
    output logic [9:0]  yCenter,
    output logic        found,
    output logic        valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y} state_t;

    state_t      state;
    logic [28:0] y_lat;
    logic [28:0] dividend;
    logic [28:0] quot;
    logic [19:0] divisor;
    logic [20:0] rem;
    logic [4:0]  bit_cnt;
    logic [9:0]  x_sat;

    // One restoring step: the remainder stays below the divisor, so 21 bits hold the shift.
    logic [20:0] shifted_c;
    logic        fits_c;
    logic [20:0] rem_next_c;
    logic [28:0] quot_next_c;

    always_comb begin
        shifted_c   = {rem[19:0], dividend[28]};
        fits_c      = (shifted_c >= {1'b0, divisor});
        rem_next_c  = fits_c ? (shifted_c - {1'b0, divisor}) : shifted_c;
        quot_next_c = {quot[27:0], fits_c};
    end

    function automatic logic [9:0] saturate(input logic [28:0] q);
        return (q > 29'(QMAX)) ? QMAX : q[9:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            y_lat    <= '0;
            dividend <= '0;
            quot     <= '0;
            divisor  <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            x_sat    <= '0;
            xCenter  <= '0;
            yCenter  <= '0;
            found    <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (total >= MIN_TOTAL) begin
                            divisor  <= total;
                            dividend <= xTop;
                            y_lat    <= yTop;
                            rem      <= '0;
                            quot     <= '0;
                            bit_cnt  <= 5'd28;
                            busy     <= 1'b1;
                            state    <= DIV_X;
                        end else begin
                            // Too few pixels: report "not found" but keep the old centers.
                            found <= 1'b0;
                            valid <= 1'b1;
                        end
                    end
                end
                DIV_X: begin
                    overrun  <= start;
                    rem      <= rem_next_c;
                    dividend <= {dividend[27:0], 1'b0};
                    quot     <= quot_next_c;
                    if (bit_cnt == 5'd0) begin
                        x_sat    <= saturate(quot_next_c);
                        rem      <= '0;
                        dividend <= y_lat;
                        quot     <= '0;
                        bit_cnt  <= 5'd28;
                        state    <= DIV_Y;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end
                end
                DIV_Y: begin
                    overrun  <= start;
                    rem      <= rem_next_c;
                    dividend <= {dividend[27:0], 1'b0};
                    quot     <= quot_next_c;
                    if (bit_cnt == 5'd0) begin
                        xCenter <= x_sat;
                        yCenter <= saturate(quot_next_c);
                        found   <= 1'b1;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_divide_sequencer.sv
// Self-checking bench for com_divide_sequencer: vector table with a result scoreboard,
// plus hand sequences for overrun, mid-division reset and reset/start collision.
module tb_com_divide_sequencer;

    localparam int unsigned FULL_LAT = 58;

    logic        clk;
    logic        reset;
    logic        start;
    logic [28:0] x_top;
    logic [28:0] y_top;
    logic [19:0] total;
    logic [9:0]  x_center;
    logic [9:0]  y_center;
    logic        found;
    logic        valid;
    logic        busy;
    logic        overrun;

    com_divide_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .xTop   (x_top),
        .yTop   (y_top),
        .total  (total),
        .xCenter(x_center),
        .yCenter(y_center),
        .found  (found),
        .valid  (valid),
        .busy   (busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] xt;
        logic [28:0] yt;
        logic [19:0] tot;
        int          ex;
        int          ey;
        int          ef;
    } vec_t;

    typedef struct {
        int ex;
        int ey;
        int ef;
        int lat;
        int start_cyc;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   ovr_cnt;
    logic prev_valid;
    logic prev_ovr;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Advance one clock and examine outputs just after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("x_center", int'(x_center), e.ex);
                chk("y_center", int'(y_center), e.ey);
                chk("found", int'(found), e.ef);
                chk("latency", cyc - e.start_cyc, e.lat);
            end
        end
        if (valid && prev_valid) chk("valid_one_cycle", 2, 1);
        if (overrun && prev_ovr) chk("overrun_one_cycle", 2, 1);
        if (overrun) ovr_cnt++;
        prev_valid = valid;
        prev_ovr   = overrun;
    endtask

    task automatic drive_start(input logic [28:0] xt, input logic [28:0] yt, input logic [19:0] tot);
        start = 1'b1;
        x_top = xt;
        y_top = yt;
        total = tot;
    endtask

    task automatic push_exp(input int ex, input int ey, input int ef, input int lat);
        exp_t e;
        e.ex = ex;
        e.ey = ey;
        e.ef = ef;
        e.lat = lat;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            chk("result_timeout", int'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic do_frame(input vec_t v);
        int short_f;
        short_f = (v.tot < 20'd1) ? 1 : 0;
        push_exp(v.ex, v.ey, v.ef, short_f ? 0 : int'(FULL_LAT));
        drive_start(v.xt, v.yt, v.tot);
        tick();
        start = 1'b0;
        x_top = '1;
        y_top = '1;
        total = 20'd3;
        chk("busy_after_accept", int'(busy), short_f ? 0 : 1);
        wait_done();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        x_top = '0;
        y_top = '0;
        total = '0;
        checks = 0;
        errors = 0;
        cyc = 0;
        ovr_cnt = 0;
        prev_valid = 1'b0;
        prev_ovr = 1'b0;

        vecs[0] = '{29'd3200, 29'd2400, 20'd10, 320, 240, 1};
        vecs[1] = '{29'd0, 29'd0, 20'd0, 320, 240, 0};
        vecs[2] = '{29'd21, 29'd7, 20'd4, 5, 1, 1};
        vecs[3] = '{29'd268435456, 29'd5, 20'd1, 1023, 5, 1};
        vecs[4] = '{29'd536870911, 29'd1000000, 20'd1048575, 512, 0, 1};
        vecs[5] = '{29'd7161, 29'd7168, 20'd7, 1023, 1023, 1};
        vecs[6] = '{29'd7167, 29'd6, 20'd7, 1023, 0, 1};

        tick();
        tick();
        reset = 1'b0;
        chk("reset_x", int'(x_center), 0);
        chk("reset_y", int'(y_center), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            do_frame(vecs[i]);
            tick();
        end

        // Starts at E+10 and E+58 are overruns; the one at E+59 is accepted.
        ovr_cnt = 0;
        push_exp(320, 240, 1, int'(FULL_LAT));
        drive_start(29'd3200, 29'd2400, 20'd10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        drive_start(29'd99, 29'd77, 20'd3);
        tick();
        start = 1'b0;
        chk("overrun_e10", int'(overrun), 1);
        chk("busy_e10", int'(busy), 1);
        for (int i = 0; i < 47; i++) tick();
        drive_start(29'd50, 29'd60, 20'd2);
        tick();
        chk("overrun_e58", int'(overrun), 1);
        chk("busy_e58", int'(busy), 0);
        chk("sb_drained_e58", int'(sb.size()), 0);
        push_exp(25, 30, 1, int'(FULL_LAT));
        tick();
        start = 1'b0;
        chk("accept_e59_busy", int'(busy), 1);
        chk("accept_e59_overrun", int'(overrun), 0);
        wait_done();
        chk("overrun_count", ovr_cnt, 2);
        tick();

        // Reset at E+20 aborts the frame without a valid pulse.
        drive_start(29'd3200, 29'd2400, 20'd10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_x", int'(x_center), 0);
        chk("abort_y", int'(y_center), 0);
        chk("abort_found", int'(found), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        for (int i = 0; i < 70; i++) tick();
        do_frame(vecs[2]);
        tick();

        // Reset and start on the same edge: start is dropped.
        reset = 1'b1;
        drive_start(29'd3200, 29'd2400, 20'd10);
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("collide_busy", int'(busy), 0);
        chk("collide_x", int'(x_center), 0);
        for (int i = 0; i < 70; i++) tick();
        chk("collide_no_valid", int'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
